// File: rtl/ex_flush_pkg.sv
// ex_flush_pkg: shared flush codes, request priorities and phase defaults
package ex_flush_pkg;

    localparam int NUM_PHASES_DEF   = 8;
    localparam int SAMPLE_PHASE_DEF = 4;

    typedef enum logic [1:0] {
        FLUSH_DISABLE = 2'd0,
        FLUSH_CYCLE_1 = 2'd1,
        FLUSH_CYCLE_2 = 2'd2
    } flush_code_e;

    // PRIO_NONE doubles as the "queue empty" marker
    typedef enum logic [1:0] {
        PRIO_NONE = 2'd0,
        PRIO_BR   = 2'd1,
        PRIO_JMP  = 2'd2,
        PRIO_TRAP = 2'd3
    } prio_e;

endpackage

// File: rtl/ex_phase_cnt.sv
// ex_phase_cnt: modulo phase counter with a strobe one cycle before the sample phase
module ex_phase_cnt #(
    parameter int NUM_PHASES   = 8,
    parameter int SAMPLE_PHASE = 4,
    parameter int CW           = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] cnt_o,
    output logic          pre_sample_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // wrap at NUM_PHASES-1; flag when the upcoming value is the sample phase
    always_comb begin
        cnt_d        = (cnt_q == CW'(NUM_PHASES - 1)) ? '0 : cnt_q + 1'b1;
        pre_sample_o = (cnt_d == CW'(SAMPLE_PHASE));
    end

    // phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_flush_req_gen.sv
// ex_flush_req_gen: arbitrates EX redirects into a one-entry queue issued in the sample phase
module ex_flush_req_gen
    import ex_flush_pkg::*;
#(
    parameter int NUM_PHASES   = NUM_PHASES_DEF,
    parameter int SAMPLE_PHASE = SAMPLE_PHASE_DEF,
    parameter int AW           = 32
) (
    input  logic          hclk,
    input  logic          hrstn,
    input  logic          br_vld,
    input  logic [AW-1:0] br_tgt,
    input  logic          jmp_vld,
    input  logic [AW-1:0] jmp_tgt,
    input  logic          trap_vld,
    input  logic [AW-1:0] trap_vec,
    input  logic          flush_stall,
    output logic [3:0]    cycle_cnt,
    output logic [1:0]    flush,
    output logic          redir_vld,
    output logic [AW-1:0] redir_pc,
    output logic          req_pend
);

    logic          issue;
    prio_e         ev_prio;
    flush_code_e   ev_code;
    logic [AW-1:0] ev_pc;
    logic          take_ev;
    logic          mrg_vld;
    flush_code_e   mrg_code;
    logic [AW-1:0] mrg_pc;

    prio_e         pend_prio_q, pend_prio_d;
    flush_code_e   pend_code_q, pend_code_d;
    logic [AW-1:0] pend_pc_q, pend_pc_d;
    flush_code_e   flush_q, flush_d;
    logic          redir_vld_q, redir_vld_d;
    logic [AW-1:0] redir_pc_q, redir_pc_d;

    ex_phase_cnt #(
        .NUM_PHASES  (NUM_PHASES),
        .SAMPLE_PHASE(SAMPLE_PHASE),
        .CW          (4)
    ) u_phase (
        .clk         (hclk),
        .rst_n       (hrstn),
        .cnt_o       (cycle_cnt),
        .pre_sample_o(issue)
    );

    // pick this cycle's winning event; wrong-path branch/jump ignored under stall
    always_comb begin
        ev_prio = PRIO_NONE;
        ev_code = FLUSH_DISABLE;
        ev_pc   = '0;
        if (trap_vld) begin
            ev_prio = PRIO_TRAP;
            ev_code = FLUSH_CYCLE_2;
            ev_pc   = trap_vec;
        end else if (jmp_vld && !flush_stall) begin
            ev_prio = PRIO_JMP;
            ev_code = FLUSH_CYCLE_1;
            ev_pc   = jmp_tgt;
        end else if (br_vld && !flush_stall) begin
            ev_prio = PRIO_BR;
            ev_code = FLUSH_CYCLE_1;
            ev_pc   = br_tgt;
        end
    end

    // merge with the queue (strictly higher priority replaces), then issue or hold
    always_comb begin
        take_ev     = ev_prio > pend_prio_q;
        mrg_vld     = take_ev || (pend_prio_q != PRIO_NONE);
        mrg_code    = take_ev ? ev_code : pend_code_q;
        mrg_pc      = take_ev ? ev_pc : pend_pc_q;
        pend_prio_d = issue ? PRIO_NONE : (take_ev ? ev_prio : pend_prio_q);
        pend_code_d = issue ? FLUSH_DISABLE : mrg_code;
        pend_pc_d   = issue ? '0 : mrg_pc;
        flush_d     = (issue && mrg_vld) ? mrg_code : FLUSH_DISABLE;
        redir_vld_d = issue && mrg_vld;
        redir_pc_d  = (issue && mrg_vld) ? mrg_pc : redir_pc_q;
    end

    // queue and output registers; reset drops any pending request
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            pend_prio_q <= PRIO_NONE;
            pend_code_q <= FLUSH_DISABLE;
            pend_pc_q   <= '0;
            flush_q     <= FLUSH_DISABLE;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            pend_prio_q <= pend_prio_d;
            pend_code_q <= pend_code_d;
            pend_pc_q   <= pend_pc_d;
            flush_q     <= flush_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    assign flush     = flush_q;
    assign redir_vld = redir_vld_q;
    assign redir_pc  = redir_pc_q;

    // queue valid as a register so req_pend has no combinational path
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) req_pend <= 1'b0;
        else        req_pend <= pend_prio_d != PRIO_NONE;
    end

endmodule

// File: tb/tb_ex_flush_req_gen.sv
// tb_ex_flush_req_gen: table-driven revolutions with a scoreboard checked at the sample phase
module tb_ex_flush_req_gen;

    logic        hclk = 1'b0;
    logic        hrstn = 1'b0;
    logic        br_vld = 1'b0, jmp_vld = 1'b0, trap_vld = 1'b0, flush_stall = 1'b0;
    logic [31:0] br_tgt = '0, jmp_tgt = '0, trap_vec = '0;
    logic [3:0]  cycle_cnt;
    logic [1:0]  flush;
    logic        redir_vld;
    logic [31:0] redir_pc;
    logic        req_pend;

    int errors = 0;
    int checks = 0;
    logic mon_on = 1'b0;

    typedef struct packed {
        logic        vld;
        logic [1:0]  code;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [7:0]  br_m, jmp_m, trap_m, stall_m, pend_m;
        logic [31:0] br_tgt, jmp_tgt, trap_vec;
        exp_t        exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    ex_flush_req_gen #(.NUM_PHASES(8), .SAMPLE_PHASE(4), .AW(32)) dut (
        .hclk(hclk), .hrstn(hrstn),
        .br_vld(br_vld), .br_tgt(br_tgt),
        .jmp_vld(jmp_vld), .jmp_tgt(jmp_tgt),
        .trap_vld(trap_vld), .trap_vec(trap_vec),
        .flush_stall(flush_stall),
        .cycle_cnt(cycle_cnt), .flush(flush),
        .redir_vld(redir_vld), .redir_pc(redir_pc),
        .req_pend(req_pend)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_phase(input logic [3:0] p);
        int n = 0;
        while (cycle_cnt !== p && n < 16) begin
            @(negedge hclk);
            n++;
        end
        chk("phase_sync", {28'd0, cycle_cnt}, {28'd0, p});
    endtask

    // scoreboard consumer: the sample phase pops one expectation, other phases must be idle
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk);
            if (mon_on) begin
                if (cycle_cnt == 4'd4) begin
                    e = (sb.size() > 0) ? sb.pop_front() : exp_t'(0);
                    chk("issue_vld", {31'd0, redir_vld}, {31'd0, e.vld});
                    chk("issue_flush", {30'd0, flush}, {30'd0, e.code});
                    if (e.vld) chk("issue_pc", redir_pc, e.pc);
                end else begin
                    chk("idle_flush", {30'd0, flush}, 32'd0);
                    chk("idle_redir", {31'd0, redir_vld}, 32'd0);
                end
            end
        end
    end

    initial begin
        // br,jmp,trap,stall,pend masks (bit = phase); targets; expected issue at this revolution's phase 4
        vecs[0]  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h0C, 32'h100, 32'h0,   32'h0,   '{1'b1, 2'd1, 32'h100}};
        vecs[1]  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h0E, 32'h200, 32'h0,   32'h80,  '{1'b1, 2'd2, 32'h80}};
        vecs[2]  = '{8'h04, 8'h02, 8'h00, 8'h00, 8'h0C, 32'h400, 32'h300, 32'h0,   '{1'b1, 2'd1, 32'h300}};
        vecs[3]  = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h00, 32'h0,   32'h500, 32'h80,  '{1'b1, 2'd2, 32'h80}};
        vecs[4]  = '{8'h10, 8'h00, 8'h00, 8'h00, 8'hE0, 32'h600, 32'h0,   32'h0,   '{1'b0, 2'd0, 32'h0}};
        vecs[5]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 32'h0,   32'h0,   32'h0,   '{1'b1, 2'd1, 32'h600}};
        vecs[6]  = '{8'h09, 8'h02, 8'h04, 8'h00, 8'h0E, 32'h700, 32'h710, 32'h720, '{1'b1, 2'd2, 32'h720}};
        vecs[7]  = '{8'h04, 8'h08, 8'h00, 8'h00, 8'h08, 32'h750, 32'h760, 32'h0,   '{1'b1, 2'd1, 32'h760}};
        vecs[8]  = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 32'h0,   32'h0,   32'h780, '{1'b0, 2'd0, 32'h0}};
        vecs[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 32'h0,   32'h0,   32'h0,   '{1'b1, 2'd2, 32'h780}};
        vecs[10] = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h0E, 32'h0,   32'h800, 32'h0,   '{1'b1, 2'd1, 32'h800}};
        vecs[11] = '{8'h02, 8'h00, 8'h00, 8'h0F, 8'h00, 32'h900, 32'h0,   32'h0,   '{1'b0, 2'd0, 32'h0}};

        // reset values, then free-running count with no flush activity
        repeat (3) @(negedge hclk);
        chk("rst_cnt", {28'd0, cycle_cnt}, 32'd0);
        chk("rst_pc", redir_pc, 32'd0);
        chk("rst_pend", {31'd0, req_pend}, 32'd0);
        hrstn  = 1'b1;
        mon_on = 1'b1;
        for (int i = 0; i < 17; i++) begin
            chk("wrap_cnt", {28'd0, cycle_cnt}, 32'(i % 8));
            @(negedge hclk);
        end

        // one revolution per vector: expectation pushed at phase 0, inputs driven per phase
        for (int v = 0; v < 12; v++) begin
            wait_phase(4'd0);
            sb.push_back(vecs[v].exp);
            for (int p = 0; p < 8; p++) begin
                if (p > 0) @(negedge hclk);
                chk($sformatf("pend_v%0d_p%0d", v, p), {31'd0, req_pend}, {31'd0, vecs[v].pend_m[p]});
                br_vld      = vecs[v].br_m[p];
                jmp_vld     = vecs[v].jmp_m[p];
                trap_vld    = vecs[v].trap_m[p];
                flush_stall = vecs[v].stall_m[p];
                br_tgt      = vecs[v].br_tgt;
                jmp_tgt     = vecs[v].jmp_tgt;
                trap_vec    = vecs[v].trap_vec;
            end
            @(negedge hclk);
        end
        br_vld = 1'b0; jmp_vld = 1'b0; trap_vld = 1'b0; flush_stall = 1'b0;

        // reset while a request is pending: dropped, nothing issued afterwards
        wait_phase(4'd0);
        @(negedge hclk);
        br_vld = 1'b1;
        br_tgt = 32'hA00;
        @(negedge hclk);
        br_vld = 1'b0;
        chk("mid_pend", {31'd0, req_pend}, 32'd1);
        hrstn = 1'b0;
        #1;
        chk("mid_rst_cnt", {28'd0, cycle_cnt}, 32'd0);
        chk("mid_rst_flush", {30'd0, flush}, 32'd0);
        chk("mid_rst_redir", {31'd0, redir_vld}, 32'd0);
        chk("mid_rst_pc", redir_pc, 32'd0);
        chk("mid_rst_pend", {31'd0, req_pend}, 32'd0);
        repeat (2) @(negedge hclk);
        hrstn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("post_rst_pend", {31'd0, req_pend}, 32'd0);
            @(negedge hclk);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
